// File: rtl/adder_pkg.sv
// Shared types and default sizing for the sequential wide adder.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 128;
    localparam int DEFAULT_CHUNK = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/repple_carray_adder_nBit.sv
// n-bit ripple-carry adder built from a chain of full-adder cells.
module repple_carray_adder_nBit #(
    parameter int n = 32
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         cout
);

    logic [n:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < n; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[n];

endmodule

// File: rtl/seq_wide_adder.sv
// WIDTH-bit adder that reuses one CHUNK-bit ripple adder over NCH cycles,
// with a valid/ready handshake on both sides.
module seq_wide_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NCH   = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    if (CHUNK <= 0) begin : g_bad_chunk
        $error("seq_wide_adder: CHUNK must be nonzero");
    end else if (WIDTH % CHUNK != 0) begin : g_bad_ratio
        $error("seq_wide_adder: WIDTH must be a multiple of CHUNK");
    end

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic [CHUNK-1:0]   chunk_sum;
    logic               chunk_cout;
    logic               accept;
    logic               last_chunk;

    assign accept     = (state == IDLE) && in_valid;
    assign last_chunk = (idx == IDX_W'(NCH - 1));

    repple_carray_adder_nBit #(
        .n(CHUNK)
    ) u_chunk_adder (
        .a   (a_reg[int'(idx) * CHUNK +: CHUNK]),
        .b   (b_reg[int'(idx) * CHUNK +: CHUNK]),
        .cin (carry),
        .sum (chunk_sum),
        .cout(chunk_cout)
    );

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output gets a default first, so no path infers a latch.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = RUN;
            end
            RUN: begin
                if (last_chunk) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: operand registers carry no reset; they are only read after an accept loads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= a;
            b_reg <= b;
        end
    end

    // The carry register doubles as the latched cin for chunk 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            idx   <= '0;
            carry <= cin;
        end else if (state == RUN) begin
            sum[int'(idx) * CHUNK +: CHUNK] <= chunk_sum;
            carry <= chunk_cout;
            idx   <= idx + IDX_W'(1);
            if (last_chunk) cout <= chunk_cout;
        end
    end

endmodule

// File: tb/tb_seq_wide_adder.sv
// Bench for seq_wide_adder: directed table, random vectors, handshake corners.
module tb_seq_wide_adder;

    localparam int WIDTH = 128;
    localparam int CHUNK = 32;
    localparam int NCH   = WIDTH / CHUNK;

    typedef logic [WIDTH:0] wide_t;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    seq_wide_adder #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic wide_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    input logic c);
        return {1'b0, x} + {1'b0, y} + wide_t'(c);
    endfunction

    function automatic logic [WIDTH-1:0] rand_wide();
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
        // Bias some chunks to all ones so carries cross chunk boundaries often.
        for (int i = 0; i < WIDTH / 32; i++)
            if ($urandom_range(0, 3) == 0) r[i*32 +: 32] = '1;
        return r;
    endfunction

    task automatic check(input string name, input wide_t act, input wide_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts from IDLE; returns once out_valid is seen (or the budget runs out).
    task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                          input logic op_c, output logic [WIDTH-1:0] rs,
                          output logic rc, output int lat);
        check("in_ready_idle", wide_t'(in_ready), 1);
        a        = op_a;
        b        = op_b;
        cin      = op_c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("in_ready_run", wide_t'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        rs = sum;
        rc = cout;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    vec_t             vecs[6];
    logic [WIDTH-1:0] rs;
    logic             rc;
    int               lat;
    wide_t            exp;
    wide_t            exp_q[$];
    logic [WIDTH-1:0] sa[3];
    logic [WIDTH-1:0] sb[3];
    logic             sc[3];
    int               t_out[3];
    int               sent;
    int               got;
    logic             acc;

    initial begin
        vecs[0] = '{"full_ripple", '1, 128'd1, 1'b0, 128'd0, 1'b1};
        vecs[1] = '{"chunk_boundary", 128'hFFFFFFFF, 128'd1, 1'b0, 128'h1_00000000, 1'b0};
        vecs[2] = '{"cin_only", 128'd0, 128'd0, 1'b1, 128'd1, 1'b0};
        vecs[3] = '{"all_zero", 128'd0, 128'd0, 1'b0, 128'd0, 1'b0};
        vecs[4] = '{"ones_ones_cin", '1, '1, 1'b1, '1, 1'b1};
        vecs[5] = '{"alt_pattern", {32{4'hA}}, {32{4'h5}}, 1'b1, 128'd0, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        #1;
        check("reset_in_ready", wide_t'(in_ready), 1);
        check("reset_out_valid", wide_t'(out_valid), 0);
        check("reset_sum", wide_t'(sum), 0);
        check("reset_cout", wide_t'(cout), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Directed table: expected values are hand-derived constants.
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat);
            check({vecs[i].name, "_latency"}, wide_t'(lat), wide_t'(NCH));
            check({vecs[i].name, "_sum"}, wide_t'(rs), wide_t'(vecs[i].exp_sum));
            check({vecs[i].name, "_cout"}, wide_t'(rc), wide_t'(vecs[i].exp_cout));
            consume();
            check({vecs[i].name, "_back_idle"}, wide_t'(out_valid), 0);
        end

        // Random operands against the arithmetic model.
        for (int i = 0; i < 20; i++) begin
            sa[0] = rand_wide();
            sb[0] = rand_wide();
            sc[0] = 1'($urandom_range(0, 1));
            exp   = model(sa[0], sb[0], sc[0]);
            run_op(sa[0], sb[0], sc[0], rs, rc, lat);
            check("rand_latency", wide_t'(lat), wide_t'(NCH));
            check("rand_result", {rc, rs}, exp);
            consume();
        end

        // Backpressure: result held while consumer stalls, new operands ignored.
        sa[0] = rand_wide();
        sb[0] = rand_wide();
        exp   = model(sa[0], sb[0], 1'b1);
        run_op(sa[0], sb[0], 1'b1, rs, rc, lat);
        a        = ~sa[0];
        b        = ~sb[0];
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_out_valid", wide_t'(out_valid), 1);
            check("bp_in_ready", wide_t'(in_ready), 0);
            check("bp_result", {cout, sum}, exp);
        end
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("bp_release_in_ready", wide_t'(in_ready), 1);
        check("bp_release_out_valid", wide_t'(out_valid), 0);
        tick();
        check("bp_no_stray_accept", wide_t'(in_ready), 1);

        // Streaming: in_valid and out_ready held high for three operand pairs.
        for (int i = 0; i < 3; i++) begin
            sa[i] = rand_wide();
            sb[i] = rand_wide();
            sc[i] = 1'($urandom_range(0, 1));
        end
        sent      = 0;
        got       = 0;
        a         = sa[0];
        b         = sb[0];
        cin       = sc[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int t = 0; t < 60 && got < 3; t++) begin
            acc = in_ready && in_valid;
            if (acc) begin
                exp_q.push_back(model(a, b, cin));
                sent++;
            end
            tick();
            if (acc) begin
                if (sent < 3) begin
                    a   = sa[sent];
                    b   = sb[sent];
                    cin = sc[sent];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                t_out[got] = cyc;
                if (exp_q.size() > 0) check("stream_result", {cout, sum}, exp_q.pop_front());
                else check("stream_unexpected_result", wide_t'(out_valid), 0);
                got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stream_count", wide_t'(got), 3);
        if (got == 3) begin
            check("stream_gap_1", wide_t'(t_out[1] - t_out[0]), wide_t'(NCH + 2));
            check("stream_gap_2", wide_t'(t_out[2] - t_out[1]), wide_t'(NCH + 2));
        end
        tick();

        // Reset two cycles into RUN aborts the operation.
        a        = '1;
        b        = '1;
        cin      = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_in_ready", wide_t'(in_ready), 1);
        check("midrun_rst_out_valid", wide_t'(out_valid), 0);
        check("midrun_rst_sum", wide_t'(sum), 0);
        check("midrun_rst_cout", wide_t'(cout), 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_no_result", wide_t'(out_valid), 0);
        sa[0] = rand_wide();
        sb[0] = rand_wide();
        exp   = model(sa[0], sb[0], 1'b0);
        run_op(sa[0], sb[0], 1'b0, rs, rc, lat);
        check("post_rst_latency", wide_t'(lat), wide_t'(NCH));
        check("post_rst_result", {rc, rs}, exp);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
